// File: rtl/decode_hazard_ctrl.sv
// Register scoreboard + operand steering for decode: counts in-flight writers per register, picks RF/ALU/cache source.
// Latency: stall/select/full outputs are combinational from inputs and state; tracking state updates on the next edge.
// Backpressure: hazard_stall blocks issue on pipe_stall, load-use, cache miss, unresolved older writer or saturated counter.
module decode_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_writes_rd,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_rd_addr,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [ADDR_W-1:0] src2_addr,
  input  logic              pipe_stall,
  input  logic              cache_data_valid,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [1:0]        src1_sel,
  output logic [1:0]        src2_sel,
  output logic              sb_full,
  output logic              sb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [1:0]       SEL_RF    = 2'd0;
  localparam logic [1:0]       SEL_ALU   = 2'd1;
  localparam logic [1:0]       SEL_CACHE = 2'd2;

  // Per-register count of issued-but-not-written-back producers.
  logic [CNT_W-1:0] pending_cnt [NUM_REGS];

  // Producer currently in the ALU stage.
  logic              slot_alu_vld;
  logic [ADDR_W-1:0] slot_alu_rd;
  logic              slot_alu_ld;

  // Producer currently in the cache stage.
  logic              slot_cache_vld;
  logic [ADDR_W-1:0] slot_cache_rd;
  logic              slot_cache_ld;

  logic                issue_accept;
  logic                src1_stall;
  logic                src2_stall;
  logic [NUM_REGS-1:0] cnt_inc;
  logic [NUM_REGS-1:0] cnt_dec;
  logic                underflow_hit;

  // Resolve one decode operand: returns {stall, sel}. The youngest producer
  // (ALU stage) shadows older ones; the counter only catches writers that
  // have already left the cache stage but not yet written back.
  function automatic logic [2:0] resolve(
    input logic              used,
    input logic [ADDR_W-1:0] addr,
    input logic              alu_vld,
    input logic [ADDR_W-1:0] alu_rd,
    input logic              alu_ld,
    input logic              cache_vld,
    input logic [ADDR_W-1:0] cache_rd,
    input logic              cache_ld,
    input logic              cache_dv,
    input logic              cnt_nz
  );
    logic [2:0] res;
    res = {1'b0, SEL_RF};
    if (used) begin
      if (alu_vld && alu_rd == addr) begin
        res = alu_ld ? {1'b1, SEL_RF} : {1'b0, SEL_ALU};
      end else if (cache_vld && cache_rd == addr) begin
        res = (!cache_ld || cache_dv) ? {1'b0, SEL_CACHE} : {1'b1, SEL_RF};
      end else if (cnt_nz) begin
        res = {1'b1, SEL_RF};
      end
    end
    return res;
  endfunction

  // Operand steering, structural hazard check and the combined stall.
  always_comb begin
    logic [2:0] r1;
    logic [2:0] r2;
    r1 = resolve(src1_used, src1_addr, slot_alu_vld, slot_alu_rd, slot_alu_ld,
                 slot_cache_vld, slot_cache_rd, slot_cache_ld, cache_data_valid,
                 pending_cnt[src1_addr] != CNT_ZERO);
    r2 = resolve(src2_used, src2_addr, slot_alu_vld, slot_alu_rd, slot_alu_ld,
                 slot_cache_vld, slot_cache_rd, slot_cache_ld, cache_data_valid,
                 pending_cnt[src2_addr] != CNT_ZERO);
    src1_stall   = r1[2];
    src1_sel     = r1[1:0];
    src2_stall   = r2[2];
    src2_sel     = r2[1:0];
    sb_full      = issue_writes_rd && (pending_cnt[issue_rd_addr] == CNT_MAX);
    hazard_stall = pipe_stall | src1_stall | src2_stall | sb_full;
    issue_accept = issue_valid & ~hazard_stall;
  end

  // Per-register increment/decrement requests; a write-back to an idle
  // register with no matching issue is an underflow.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_inc[r] = issue_accept && issue_writes_rd && (issue_rd_addr == ADDR_W'(r));
      cnt_dec[r] = wb_valid && (wb_addr == ADDR_W'(r));
    end
    underflow_hit = wb_valid && (pending_cnt[wb_addr] == CNT_ZERO) &&
                    !(issue_accept && issue_writes_rd && issue_rd_addr == wb_addr);
  end

  // Pending-writer counters; simultaneous issue and write-back cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) pending_cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) pending_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cnt_inc[r] && !cnt_dec[r] && pending_cnt[r] != CNT_MAX) begin
          pending_cnt[r] <= pending_cnt[r] + 1'b1;
        end else if (cnt_dec[r] && !cnt_inc[r] && pending_cnt[r] != CNT_ZERO) begin
          pending_cnt[r] <= pending_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Stage tracking slots follow the pipeline and freeze with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_alu_vld   <= 1'b0;
      slot_alu_rd    <= '0;
      slot_alu_ld    <= 1'b0;
      slot_cache_vld <= 1'b0;
      slot_cache_rd  <= '0;
      slot_cache_ld  <= 1'b0;
    end else if (flush) begin
      slot_alu_vld   <= 1'b0;
      slot_cache_vld <= 1'b0;
    end else if (!pipe_stall) begin
      slot_alu_vld   <= issue_accept & issue_writes_rd;
      slot_alu_rd    <= issue_rd_addr;
      slot_alu_ld    <= issue_is_load;
      slot_cache_vld <= slot_alu_vld;
      slot_cache_rd  <= slot_alu_rd;
      slot_cache_ld  <= slot_alu_ld;
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_underflow <= 1'b0;
    end else if (underflow_hit) begin
      sb_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: inputs change 1 time unit after the rising edge,
// outputs are checked 1 time unit later.
module tb_decode_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid, issue_writes_rd, issue_is_load;
  logic [4:0] issue_rd_addr;
  logic       src1_used, src2_used;
  logic [4:0] src1_addr, src2_addr;
  logic       pipe_stall, cache_data_valid, wb_valid, flush;
  logic [4:0] wb_addr;
  logic       hazard_stall, sb_full, sb_underflow;
  logic [1:0] src1_sel, src2_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decode_hazard_ctrl #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_writes_rd(issue_writes_rd),
    .issue_is_load(issue_is_load), .issue_rd_addr(issue_rd_addr),
    .src1_used(src1_used), .src2_used(src2_used),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .pipe_stall(pipe_stall), .cache_data_valid(cache_data_valid),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .hazard_stall(hazard_stall), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .sb_full(sb_full), .sb_underflow(sb_underflow)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_writes_rd = 0; issue_is_load = 0; issue_rd_addr = 0;
    src1_used = 0; src2_used = 0; src1_addr = 0; src2_addr = 0;
    pipe_stall = 0; cache_data_valid = 0; wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld);
    issue_valid = 1; issue_writes_rd = 1; issue_rd_addr = rd; issue_is_load = ld;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid = 1; wb_addr = a;
  endtask

  initial begin
    idle();
    reset = 0;
    #12;
    #1;
    chk("rst_stall", hazard_stall, 0);
    chk("rst_sel1", src1_sel, 0);
    chk("rst_sel2", src2_sel, 0);
    chk("rst_full", sb_full, 0);
    chk("rst_uf", sb_underflow, 0);
    reset = 1;
    next_cycle();

    // ALU bypass chain on r3
    issue(3, 0); #1;
    chk("add_issue", hazard_stall, 0);
    next_cycle();
    issue(10, 0); src1_used = 1; src1_addr = 3; #1;
    chk("sub_stall", hazard_stall, 0);
    chk("sub_sel1_alu", src1_sel, 1);
    next_cycle();
    src1_used = 1; src1_addr = 3; #1;
    chk("c2_stall", hazard_stall, 0);
    chk("c2_sel1_cache", src1_sel, 2);
    next_cycle();
    src1_used = 1; src1_addr = 3; wb(3); #1;
    chk("wb_cycle_stall", hazard_stall, 1);
    next_cycle();
    src1_used = 1; src1_addr = 3; wb(10); #1;
    chk("after_wb_stall", hazard_stall, 0);
    chk("after_wb_sel", src1_sel, 0);
    next_cycle();

    // Load-use on r5
    issue(5, 1); #1;
    chk("ld_issue", hazard_stall, 0);
    next_cycle();
    issue(6, 0); src2_used = 1; src2_addr = 5; #1;
    chk("ld_use_stall", hazard_stall, 1);
    next_cycle();
    pipe_stall = 1; src2_used = 1; src2_addr = 5; #1;
    chk("miss_hold_stall", hazard_stall, 1);
    next_cycle();
    issue(6, 0); src2_used = 1; src2_addr = 5; cache_data_valid = 0; #1;
    chk("miss_stall", hazard_stall, 1);
    cache_data_valid = 1; #1;
    chk("hit_stall", hazard_stall, 0);
    chk("hit_sel2", src2_sel, 2);
    next_cycle();
    wb(5); next_cycle();
    wb(6); #1;
    chk("no_uf_yet", sb_underflow, 0);
    next_cycle();

    // Counter saturation on r7
    for (int i = 0; i < 3; i++) begin
      issue(7, 0); #1;
      chk("r7_fill", hazard_stall, 0);
      next_cycle();
    end
    issue(7, 0); #1;
    chk("r7_full", sb_full, 1);
    chk("r7_full_stall", hazard_stall, 1);
    next_cycle();
    issue(7, 0); wb(7); #1;
    chk("r7_full_wb", sb_full, 1);
    next_cycle();
    issue_writes_rd = 1; issue_rd_addr = 7; #1;
    chk("r7_drop", sb_full, 0);
    chk("r7_drop_stall", hazard_stall, 0);
    next_cycle();
    wb(7); next_cycle();
    wb(7); next_cycle();

    // Simultaneous issue and write-back on r2, then underflow on r9
    issue(2, 0); next_cycle();
    issue(2, 0); wb(2); next_cycle();
    next_cycle();
    next_cycle();
    src1_used = 1; src1_addr = 2; #1;
    chk("r2_cnt1_stall", hazard_stall, 1);
    wb(2);
    next_cycle();
    src1_used = 1; src1_addr = 2; #1;
    chk("r2_cnt0_stall", hazard_stall, 0);
    chk("r2_cnt0_sel", src1_sel, 0);
    wb(9);
    next_cycle(); #1;
    chk("uf_set", sb_underflow, 1);
    next_cycle(); #1;
    chk("uf_sticky", sb_underflow, 1);

    // pipe_stall freezes a load in the ALU slot
    issue(12, 1); next_cycle();
    for (int i = 0; i < 3; i++) begin
      pipe_stall = 1; cache_data_valid = 1;
      if (i == 1) begin src1_used = 0; end else begin src1_used = 1; src1_addr = 12; end
      #1;
      chk("ps_stall", hazard_stall, 1);
      next_cycle();
    end
    src1_used = 1; src1_addr = 12; cache_data_valid = 1; #1;
    chk("ps_release_ld_use", hazard_stall, 1);
    next_cycle();
    src1_used = 1; src1_addr = 12; cache_data_valid = 1; #1;
    chk("ps_cache_stall", hazard_stall, 0);
    chk("ps_cache_sel", src1_sel, 2);
    wb(12);
    next_cycle();

    // Flush clears outstanding writers
    issue(1, 0); next_cycle();
    issue(4, 0); next_cycle();
    issue(8, 0); flush = 1; next_cycle();
    src1_used = 1; src1_addr = 1; src2_used = 1; src2_addr = 4; #1;
    chk("fl_stall", hazard_stall, 0);
    chk("fl_sel1", src1_sel, 0);
    chk("fl_sel2", src2_sel, 0);
    src2_addr = 8; #1;
    chk("fl_discard", hazard_stall, 0);
    chk("fl_uf_kept", sb_underflow, 1);
    next_cycle();

    // Asynchronous reset mid-stream
    issue(20, 0); next_cycle();
    issue(21, 1); next_cycle();
    src1_used = 1; src1_addr = 20; src2_used = 1; src2_addr = 21; #1;
    chk("pre_rst_stall", hazard_stall, 1);
    chk("pre_rst_sel1", src1_sel, 2);
    #1 reset = 0; #1;
    chk("arst_stall", hazard_stall, 0);
    chk("arst_sel1", src1_sel, 0);
    chk("arst_sel2", src2_sel, 0);
    chk("arst_uf", sb_underflow, 0);
    reset = 1;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

Register scoreboard and hazard controller for the decode stage. It tracks in-flight writers of every register-file entry, steers each decode source operand to the register file, the ALU bypass or the cache bypass, and raises a stall when no valid source exists yet. It sits beside the decode stage, fed by decode issue information, the ALU/cache stage progress and write-back. It replaces the ad-hoc per-stage rd/opcode flops with a single authority for operand readiness.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers tracked
- ADDR_W, 5, register address width (clog2 of NUM_REGS)
- CNT_W, 2, width of the per-register pending-writer counter; saturation value is 2^CNT_W-1

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- issue_valid  in  1  decode hands an instruction to ALU this cycle
- issue_writes_rd  in  1  issued instruction writes a register
- issue_is_load  in  1  issued instruction is a load (result produced in cache stage)
- issue_rd_addr  in  ADDR_W  destination of issued instruction
- src1_used / src2_used  in  1 each  decode instruction reads src1 / src2
- src1_addr / src2_addr  in  ADDR_W each  source addresses of the instruction in decode
- pipe_stall  in  1  ALU/cache stages hold this cycle
- cache_data_valid  in  1  cache stage result valid this cycle (load hit)
- wb_valid  in  1  register-file write this cycle
- wb_addr  in  ADDR_W  register written
- flush  in  1  synchronous pipeline flush (exception); clears all tracking
- hazard_stall  out  1  decode must not issue this cycle
- src1_sel / src2_sel  out  2 each  operand source: 0 RF, 1 ALU bypass, 2 cache bypass
- sb_full  out  1  destination counter of decode instruction saturated
- sb_underflow  out  1  sticky error: write-back to a register with zero pending count

## Operation
- State: pending_cnt[NUM_REGS] (CNT_W bits); two tracking slots, slot_alu and slot_cache, each {valid, rd, is_load}; sb_underflow flop.
- Issue accept = issue_valid & !hazard_stall. An issue while hazard_stall=1 is ignored entirely.
- Counter update per register r: +1 if accepted issue with issue_writes_rd and issue_rd_addr==r; -1 if wb_valid and wb_addr==r; both in same cycle -> unchanged. Decrement at 0 -> counter stays 0, sb_underflow set (sticky until reset).
- Slots advance when !pipe_stall: slot_alu <= {accepted & issue_writes_rd, issue_rd_addr, issue_is_load}; slot_cache <= slot_alu. pipe_stall=1: both slots hold, and hazard_stall is forced to 1.
- Source resolution for each used source s (unused source -> sel 0, no stall), youngest producer wins:
  - slot_alu valid, rd==s, !is_load -> sel 1.
  - slot_alu valid, rd==s, is_load -> stall (load-use).
  - else slot_cache valid, rd==s, and (!is_load or cache_data_valid) -> sel 2.
  - else slot_cache valid, rd==s, is_load, !cache_data_valid -> stall (miss).
  - else pending_cnt[s]!=0 -> stall (older writer awaiting write-back, including one writing back this cycle).
  - else sel 0.
- sb_full = issue_writes_rd & pending_cnt[issue_rd_addr]==max; it contributes to hazard_stall.
- hazard_stall = pipe_stall | src1 stall | src2 stall | sb_full.
- flush: on next edge all counters 0, both slots invalid; same-cycle issue discarded. sb_underflow unaffected.

## Timing
- hazard_stall, src*_sel, sb_full: combinational from inputs and current state, same cycle; no registered latency.
- Counters and slots update on the edge after the event; a register written back in cycle N reads as ready (sel 0) in cycle N+1.
- Reset values: all counters 0, slots invalid, sb_underflow 0; hence with idle inputs hazard_stall=0, src*_sel=0, sb_full=0.
- Reset asserted mid-operation clears state asynchronously regardless of clock; outputs return to idle values combinationally.
- Back-to-back R-type dependency: zero bubble (ALU bypass). Load-use: minimum one bubble; additional bubbles while cache_data_valid=0.

## Test plan
- Reset, then ADD r3 issued cycle 0, SUB using r3 in decode cycle 1 -> hazard_stall=0, src1_sel=1; cycle 2 consumer -> src1_sel=2; after wb r3 -> sel 0, pending_cnt[r3]=0.
- Load r5 issued cycle 0, consumer of r5 in cycle 1 -> hazard_stall=1; cycle 2 cache_data_valid=0 -> stall; cycle 3 cache_data_valid=1 -> stall low, src_sel=2.
- Three writers of r7 issued without write-back -> fourth issue with rd=r7 gets sb_full=1, hazard_stall=1; one wb r7 -> sb_full drops next cycle.
- Same-cycle issue rd=r2 and wb_valid r2 with count 1 -> count stays 1; wb_valid r9 with count 0 -> sb_underflow=1 and stays set.
- pipe_stall held 3 cycles with load in slot_alu -> slots unchanged, hazard_stall=1 throughout; release -> load moves to slot_cache.
- Outstanding writers on r1,r4 then flush -> next cycle all sources sel 0, no stall; reset deasserted-asserted mid-stream -> immediate idle outputs.
